// File: rtl/cordic_scale_comp_pkg.sv
// Shared CORDIC constants: default datapath width and the shift/add decomposition
// of the gain-inverse K used by the scale compensation stage.
package cordic_scale_comp_pkg;

  localparam int CORDIC_WIDTH_DEF = 22;

  // K = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14 + 2^-16; first four terms form stage 1
  localparam int K_TERMS        = 7;
  localparam int K_STAGE1_TERMS = 4;
  localparam int K_SHIFT [K_TERMS] = '{1, 3, 6, 9, 12, 14, 16};
  localparam bit K_SUB   [K_TERMS] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/cordic_scale_comp_if.sv
// Streaming bundle between the final micro-rotation stage, the gain compensator
// and its consumer.
interface cordic_scale_comp_if
  import cordic_scale_comp_pkg::*;
#(
  parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF
);

  logic signed [CORDIC_WIDTH-1:0] x_in;
  logic signed [CORDIC_WIDTH-1:0] y_in;
  logic                           in_valid;
  logic                           out_ready;
  logic signed [CORDIC_WIDTH-1:0] x_out;
  logic signed [CORDIC_WIDTH-1:0] y_out;
  logic                           out_valid;
  logic                           fifo_full;
  logic                           overflow;

  modport master (
    output x_in, y_in, in_valid, out_ready,
    input  x_out, y_out, out_valid, fifo_full, overflow
  );

  modport slave (
    input  x_in, y_in, in_valid, out_ready,
    output x_out, y_out, out_valid, fifo_full, overflow
  );

endinterface

// File: rtl/cordic_out_fifo.sv
// Output buffer for compensated x/y pairs; drops on push-while-full with a sticky
// overflow flag, and a pop frees room for a same-cycle push.
module cordic_out_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             not_empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    not_empty = (count != '0);
    full      = (count == (AW+1)'(DEPTH));
    do_pop    = pop && not_empty;
    do_push   = push && (!full || do_pop);
    dout      = not_empty ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cordic_scale_comp.sv
// CORDIC gain compensation: x,y scaled by K via a two-stage shift/add pipeline,
// results buffered in a small output FIFO.
module cordic_scale_comp
  import cordic_scale_comp_pkg::*;
#(
  parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  cordic_scale_comp_if.slave io
);

  localparam int SW = CORDIC_WIDTH + 1;

  // One signed K term: sign-extend, arithmetic shift (truncating), optional negate
  function automatic logic signed [SW-1:0] k_term(input logic signed [CORDIC_WIDTH-1:0] v,
                                                   input int idx);
    logic signed [SW-1:0] ext;
    logic signed [SW-1:0] sh;
    ext = {v[CORDIC_WIDTH-1], v};
    sh  = ext >>> K_SHIFT[idx];
    return K_SUB[idx] ? -sh : sh;
  endfunction

  logic signed [SW-1:0]           x_acc_p0, y_acc_p0;
  logic signed [SW-1:0]           x_sum_p1, y_sum_p1;
  logic signed [CORDIC_WIDTH-1:0] x_p1, y_p1;
  logic signed [SW-1:0]           x_acc_p1, y_acc_p1;
  logic signed [CORDIC_WIDTH-1:0] x_p2, y_p2;
  logic                           vld_p1, vld_p2;
  logic                           push;
  logic [2*CORDIC_WIDTH-1:0]      fifo_dout;

  always_comb begin
    x_acc_p0 = '0;
    y_acc_p0 = '0;
    for (int i = 0; i < K_STAGE1_TERMS; i++) begin
      x_acc_p0 = x_acc_p0 + k_term(io.x_in, i);
      y_acc_p0 = y_acc_p0 + k_term(io.y_in, i);
    end
    x_acc_p1 = x_sum_p1;
    y_acc_p1 = y_sum_p1;
    for (int i = K_STAGE1_TERMS; i < K_TERMS; i++) begin
      x_acc_p1 = x_acc_p1 + k_term(x_p1, i);
      y_acc_p1 = y_acc_p1 + k_term(y_p1, i);
    end
  end

  // p0 -> p1: partial sum of the leading terms plus the raw operand for the tail
  always_ff @(posedge clk) begin
    x_sum_p1 <= x_acc_p0;
    y_sum_p1 <= y_acc_p0;
    x_p1     <= io.x_in;
    y_p1     <= io.y_in;
  end

  // p1 -> p2: full product, low bits kept
  always_ff @(posedge clk) begin
    x_p2 <= x_acc_p1[CORDIC_WIDTH-1:0];
    y_p2 <= y_acc_p1[CORDIC_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= io.in_valid;
      vld_p2 <= vld_p1;
    end
  end

  // A stage-2 result on the same edge enable drops is in flight and is discarded
  assign push = vld_p2 && enable;

  cordic_out_fifo #(
    .WIDTH (2*CORDIC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .din       ({x_p2, y_p2}),
    .pop       (io.out_ready),
    .dout      (fifo_dout),
    .not_empty (io.out_valid),
    .full      (io.fifo_full),
    .overflow  (io.overflow)
  );

  assign io.x_out = fifo_dout[2*CORDIC_WIDTH-1:CORDIC_WIDTH];
  assign io.y_out = fifo_dout[CORDIC_WIDTH-1:0];

endmodule

// File: tb/tb_cordic_scale_comp.sv
// Directed bench for cordic_scale_comp: scaling values, streaming, back-pressure,
// full push+pop, flush and mid-stream reset.
module tb_cordic_scale_comp;

  localparam int W = 22;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  cordic_scale_comp_if #(.CORDIC_WIDTH(W)) io ();

  cordic_scale_comp #(
    .CORDIC_WIDTH (W),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .io     (io)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Hand-computed: multiples of 65536 scale by 39797 exactly; -1 -> -1, 3 -> 1, -3 -> -2
  int vx [8] = '{65536, 131072, -1, 3, -2097152, 1048576, 262144, 0};
  int vy [8] = '{-65536, 3, -3, -1, 196608, 0, -524288, -196608};
  int ex [8] = '{39797, 79594, -1, 1, -1273504, 636752, 159188, 0};
  int ey [8] = '{-39797, 1, -2, -1, 119391, 0, -318376, -119391};

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input int i);
    io.x_in     = W'(vx[i]);
    io.y_in     = W'(vy[i]);
    io.in_valid = 1'b1;
  endtask

  task automatic idle();
    io.x_in     = '0;
    io.y_in     = '0;
    io.in_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input int i);
    chk({tag, "_vld"}, io.out_valid, 1);
    chk({tag, "_x"}, io.x_out, ex[i]);
    chk({tag, "_y"}, io.y_out, ey[i]);
  endtask

  task automatic expect_empty(input string tag);
    chk({tag, "_vld"}, io.out_valid, 0);
    chk({tag, "_x"}, io.x_out, 0);
    chk({tag, "_y"}, io.y_out, 0);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    io.out_ready = 1'b0;
    idle();
    step();
    step();
    reset = 1'b0;
    expect_empty("rst");
    chk("rst_full", io.fifo_full, 0);
    chk("rst_ovf", io.overflow, 0);

    // single sample, 3-cycle latency to out_valid
    io.out_ready = 1'b1;
    io.x_in      = 22'sd1048576;
    io.y_in      = -22'sd1048576;
    io.in_valid  = 1'b1;
    step();
    idle();
    chk("scale_lat1", io.out_valid, 0);
    step();
    chk("scale_lat2", io.out_valid, 0);
    step();
    chk("scale_vld", io.out_valid, 1);
    chk("scale_x", io.x_out, 636752);
    chk("scale_y", io.y_out, -636752);
    step();
    expect_empty("scale_pop");

    // 8 back-to-back samples drain on 8 consecutive cycles
    for (int c = 0; c < 12; c++) begin
      if (c >= 3 && c <= 10) expect_head($sformatf("stream%0d", c - 3), c - 3);
      else                   expect_empty($sformatf("stream_gap%0d", c));
      if (c < 8) drive(c);
      else       idle();
      step();
    end

    // back-pressure: 6 samples into a 4-deep FIFO
    io.out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) drive(c);
      else       idle();
      step();
    end
    chk("bp_full", io.fifo_full, 1);
    chk("bp_ovf", io.overflow, 1);
    io.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_head($sformatf("bp%0d", i), i);
      step();
    end
    expect_empty("bp_drained");
    chk("bp_full_after", io.fifo_full, 0);
    chk("bp_ovf_sticky", io.overflow, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("bp_ovf_cleared", io.overflow, 0);

    // full FIFO with simultaneous push and pop
    io.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 5) drive(c);
      else       idle();
      step();
    end
    chk("fp_full_before", io.fifo_full, 1);
    expect_head("fp0", 0);
    io.out_ready = 1'b1;
    step();
    chk("fp_full_kept", io.fifo_full, 1);
    chk("fp_no_ovf", io.overflow, 0);
    for (int i = 1; i < 5; i++) begin
      expect_head($sformatf("fp%0d", i), i);
      step();
    end
    expect_empty("fp_drained");
    chk("fp_ovf_end", io.overflow, 0);

    // flush: two samples in flight when enable drops for one cycle
    io.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(c);
      step();
    end
    idle();
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    chk("fl_full", io.fifo_full, 0);
    io.out_ready = 1'b1;
    expect_head("fl0", 0);
    step();
    expect_head("fl1", 1);
    step();
    expect_empty("fl_end");
    step();
    expect_empty("fl_late");

    // reset while 3 entries are buffered and one result is in flight
    io.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(c);
      step();
    end
    idle();
    step();
    expect_head("rm_pre", 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_empty("rm_post");
    chk("rm_full", io.fifo_full, 0);
    chk("rm_ovf", io.overflow, 0);
    step();
    step();
    expect_empty("rm_inflight");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_scale_comp.md
CORDIC_SCALE_COMP -- requirements
Module: cordic_scale_comp

Interface
REQ-001 The block SHALL have parameter CORDIC_WIDTH, default 22, the signed two's-complement width of the x/y datapath.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, the output buffer depth in entries (power of two, at least 2).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  pipeline enable; low flushes the multiply pipeline.
REQ-007 x_in  input  CORDIC_WIDTH  signed x from the final micro-rotation stage.
REQ-008 y_in  input  CORDIC_WIDTH  signed y from the final micro-rotation stage.
REQ-009 in_valid  input  1  x_in/y_in valid this cycle (driven by the final stage's op_valid); no back-pressure upstream.
REQ-010 out_ready  input  1  consumer accepts the output word this cycle.
REQ-011 x_out  output  CORDIC_WIDTH  gain-compensated x at the FIFO head.
REQ-012 y_out  output  CORDIC_WIDTH  gain-compensated y at the FIFO head.
REQ-013 out_valid  output  1  FIFO non-empty; x_out/y_out hold the head entry.
REQ-014 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-015 overflow  output  1  sticky: a result was dropped because the FIFO was full.

Function
REQ-016 The block SHALL multiply x and y by K = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14 + 2^-16 (about 0.6072540, the CORDIC gain inverse) using arithmetic right shifts and add/subtract only; no multipliers.
REQ-017 Stage 1 SHALL register the sum of the first four terms; stage 2 SHALL add the last three terms and present a write to the FIFO.
REQ-018 Internal sums SHALL be CORDIC_WIDTH+1 bits wide; the result SHALL be the low CORDIC_WIDTH bits, with shifted-out bits truncated and no rounding.
REQ-019 Latency SHALL be exactly 2 cycles from an in_valid sample to the FIFO write; with the FIFO empty, out_valid SHALL assert 3 cycles after the in_valid sample.
REQ-020 Throughput SHALL be one sample per cycle, with per-stage valid bits shifted alongside the data.
REQ-021 When enable is low, both stage valid bits SHALL clear on the next edge, any in-flight data SHALL be discarded, and FIFO contents SHALL be retained.
REQ-022 A FIFO pop SHALL occur when out_valid and out_ready are both high; a push SHALL occur when stage-2 valid is high and the FIFO is not full.
REQ-023 A push while full SHALL drop the result and set overflow; overflow SHALL clear only on reset.
REQ-024 A simultaneous push and pop when full SHALL be accepted with no drop, and the count SHALL be unchanged.
REQ-025 A simultaneous push and pop when empty SHALL write the FIFO, and out_valid SHALL rise the next cycle; there SHALL be no bypass.
REQ-026 A pop while empty SHALL be ignored.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with a count of log2(FIFO_DEPTH)+1 bits.
REQ-028 Entries SHALL leave the FIFO in input order.
REQ-029 x_out and y_out SHALL be zero whenever out_valid is low.

Reset
REQ-030 When reset is high at a clock edge: stage valids, FIFO pointers, count and overflow SHALL go to 0; out_valid, fifo_full, x_out and y_out SHALL read 0 on the following cycle.
REQ-031 Reset SHALL take priority over enable and over any push or pop; a result in flight at reset SHALL be lost.

Structure
REQ-032 The K shift amounts and signs, and the default CORDIC_WIDTH, SHALL be constants in the shared CORDIC package.
REQ-033 The output buffer SHALL be one sub-module, cordic_out_fifo, parameterised by width (2*CORDIC_WIDTH) and depth.

Verification
REQ-034 Scale: x_in=1048576, y_in=-1048576, one valid, out_ready=1 -> x_out=636752, y_out=-636752 after 3 cycles.
REQ-035 Stream: 8 consecutive valids, out_ready=1 -> 8 outputs on 8 consecutive cycles, in order.
REQ-036 Back-pressure: out_ready=0, 6 valids, FIFO_DEPTH=4 -> fifo_full=1, overflow=1, then the first 4 results drain in order.
REQ-037 Full push+pop: FIFO full, out_ready=1 with a new valid -> no drop, fifo_full stays 1, overflow stays 0.
REQ-038 Flush: enable low for 1 cycle with 2 samples in flight -> those 2 are not written; earlier FIFO entries are intact.
REQ-039 Reset mid-stream: reset high for 1 cycle while the FIFO holds 3 entries -> out_valid=0, count=0, overflow=0.
